// File: rtl/rng_sched.sv
// Round-robin scheduler sharing one 4-bit Fibonacci LFSR (x^4+x^3+1) among NREQ requesters.
// Latency: req sampled in IDLE at edge k -> gnt/valid pulse in the cycle after edge k+STEPS+1.
// Backpressure: none; requesters hold req until gnt, and seed_load outside IDLE is dropped.
module rng_sched #(
   parameter int         NREQ         = 4,
   parameter int         STEPS        = 4,
   parameter logic [3:0] DEFAULT_SEED = 4'b1001
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            seed_load,
   input  logic [3:0]      seed,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic            valid,
   output logic [3:0]      rnd,
   output logic            busy,
   output logic            lock_err
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP    = 2'd1,
      DELIVER = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      lfsr_q, lfsr_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]   winner_q, winner_d;
   logic [3:0]      step_cnt_q, step_cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            valid_q, valid_d;
   logic [3:0]      rnd_q, rnd_d;
   logic            busy_q, busy_d;
   logic            lock_err_q, lock_err_d;

   logic            arb_found;
   logic [PW-1:0]   arb_idx;
   logic [PW-1:0]   cand_idx;
   int              cand;
   logic [3:0]      lfsr_adv;

   // One LFSR advance: shift left, feedback from taps 3 and 2.
   assign lfsr_adv = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

   // Round-robin pick: first requester set, scanning upward from the one after rr_ptr.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand     = (int'(rr_ptr_q) + i) % NREQ;
         cand_idx = PW'(cand);
         if (!arb_found && req[cand_idx]) begin
            arb_found = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   // Next-state and next-output logic for the IDLE -> STEP -> DELIVER cycle.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      rr_ptr_d   = rr_ptr_q;
      winner_d   = winner_q;
      step_cnt_d = step_cnt_q;
      gnt_d      = '0;
      valid_d    = 1'b0;
      rnd_d      = rnd_q;
      lock_err_d = lock_err_q;
      case (state_q)
         IDLE: begin
            // A seed load takes the slot; any pending request is arbitrated next cycle.
            if (seed_load) begin
               if (seed == 4'b0000) begin
                  lfsr_d     = DEFAULT_SEED;
                  lock_err_d = 1'b1;
               end else begin
                  lfsr_d = seed;
               end
            end else if (arb_found) begin
               winner_d   = arb_idx;
               step_cnt_d = 4'd0;
               state_d    = STEP;
            end
         end
         STEP: begin
            // An all-zero state would lock the LFSR; repair it, still counting as an advance.
            if (lfsr_q == 4'b0000) begin
               lfsr_d     = DEFAULT_SEED;
               lock_err_d = 1'b1;
            end else begin
               lfsr_d = lfsr_adv;
            end
            step_cnt_d = step_cnt_q + 4'd1;
            if (step_cnt_q == 4'(STEPS - 1)) begin
               state_d = DELIVER;
            end
         end
         DELIVER: begin
            gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << winner_q;
            valid_d  = 1'b1;
            rnd_d    = lfsr_q;
            rr_ptr_d = winner_q;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset discards any in-flight grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         lfsr_q     <= DEFAULT_SEED;
         rr_ptr_q   <= PW'(NREQ - 1);
         winner_q   <= '0;
         step_cnt_q <= 4'd0;
         gnt_q      <= '0;
         valid_q    <= 1'b0;
         rnd_q      <= 4'd0;
         busy_q     <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         rr_ptr_q   <= rr_ptr_d;
         winner_q   <= winner_d;
         step_cnt_q <= step_cnt_d;
         gnt_q      <= gnt_d;
         valid_q    <= valid_d;
         rnd_q      <= rnd_d;
         busy_q     <= busy_d;
         lock_err_q <= lock_err_d;
      end
   end

   assign gnt      = gnt_q;
   assign valid    = valid_q;
   assign rnd      = rnd_q;
   assign busy     = busy_q;
   assign lock_err = lock_err_q;

endmodule

// File: tb/tb_rng_sched.sv
// Scoreboard bench for rng_sched: stimulus pushes expected grants, a monitor pops on valid.
// Expected nibbles follow the 1-step LFSR orbit from 1001:
//   1001 0011 0110 1101 1010 0101 1011 0111 1111 1110 1100 1000 0001 0010 0100
module tb_rng_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       seed_load;
   logic [3:0] seed;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       valid;
   logic [3:0] rnd;
   logic       busy;
   logic       lock_err;

   typedef struct packed {
      logic [3:0] gnt;
      logic [3:0] rnd;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   ncyc;
   int   nv;

   always #5 clk = ~clk;

   rng_sched #(
      .NREQ        (4),
      .STEPS       (4),
      .DEFAULT_SEED(4'b1001)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .seed_load(seed_load),
      .seed     (seed),
      .req      (req),
      .gnt      (gnt),
      .valid    (valid),
      .rnd      (rnd),
      .busy     (busy),
      .lock_err (lock_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [3:0] g, input logic [3:0] r);
      exp_t x;
      x.gnt = g;
      x.rnd = r;
      sb_q.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count negedges until valid is seen; bounded so a missing grant cannot hang the run.
   task automatic wait_valid(output int n);
      bit seen;
      seen = 1'b0;
      n = -1;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         if (valid) begin
            seen = 1'b1;
            n = c;
         end
      end
      if (!seen) begin
         n_chk++;
         $display("FAIL wait_valid: no grant within 40 cycles");
      end
   endtask

   // Monitor: every valid pulse must match the oldest expected grant.
   always @(negedge clk) begin
      if (!reset && valid) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_grant: gnt=%b rnd=%b with empty scoreboard", gnt, rnd);
         end else begin
            e = sb_q.pop_front();
            check("grant_gnt", 32'(gnt), 32'(e.gnt));
            check("grant_rnd", 32'(rnd), 32'(e.rnd));
         end
      end
   end

   initial begin
      reset     = 1'b1;
      seed_load = 1'b0;
      seed      = 4'b0000;
      req       = 4'b0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_gnt",      32'(gnt),      32'h0);
      check("reset_valid",    32'(valid),    32'h0);
      check("reset_rnd",      32'(rnd),      32'h0);
      check("reset_busy",     32'(busy),     32'h0);
      check("reset_lock_err", 32'(lock_err), 32'h0);
      tick();
      reset = 1'b0;

      // Single requester held for two grants: 1001 -> 1010 -> 1111.
      tick();
      req = 4'b0001;
      push(4'b0001, 4'b1010);
      push(4'b0001, 4'b1111);
      wait_valid(ncyc);
      check("t1_latency", 32'(ncyc), 32'd7);
      check("t1_busy_at_grant", 32'(busy), 32'h0);
      wait_valid(ncyc);
      check("t1_spacing", 32'(ncyc), 32'd6);
      req = 4'b0000;

      // After gnt[0], req 0101 goes to index 2 first, then wraps to 0.
      tick();
      req = 4'b0101;
      push(4'b0100, 4'b0001);
      push(4'b0001, 4'b0011);
      wait_valid(ncyc);
      check("t3_latency", 32'(ncyc), 32'd7);
      wait_valid(ncyc);
      check("t3_spacing", 32'(ncyc), 32'd6);
      req = 4'b0000;

      // Fresh reset, all four requesting: strict rotation starting at req[0].
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      req = 4'b1111;
      push(4'b0001, 4'b1010);
      push(4'b0010, 4'b1111);
      push(4'b0100, 4'b0001);
      push(4'b1000, 4'b0011);
      push(4'b0001, 4'b0101);
      wait_valid(ncyc);
      check("t2_latency", 32'(ncyc), 32'd7);
      for (int k = 0; k < 4; k++) begin
         wait_valid(ncyc);
         check("t2_spacing", 32'(ncyc), 32'd6);
      end
      req = 4'b0000;

      // Zero seed is repaired to the default and flags lock_err.
      tick();
      seed_load = 1'b1;
      seed      = 4'b0000;
      tick();
      seed_load = 1'b0;
      @(negedge clk);
      check("t4_lock_err", 32'(lock_err), 32'h1);
      check("t4_busy_idle", 32'(busy), 32'h0);
      tick();
      req = 4'b0010;
      push(4'b0010, 4'b1010);
      wait_valid(ncyc);
      check("t4_latency", 32'(ncyc), 32'd7);
      req = 4'b0000;

      // seed_load while stepping is dropped: rnd continues the unseeded orbit.
      tick();
      req = 4'b0100;
      push(4'b0100, 4'b1111);
      tick();
      tick();
      seed_load = 1'b1;
      seed      = 4'b0110;
      check("t5_busy_step", 32'(busy), 32'h1);
      tick();
      tick();
      seed_load = 1'b0;
      wait_valid(ncyc);
      check("t5_busy_seed_ignored_timing", 32'(ncyc), 32'd3);
      req = 4'b0000;

      // seed_load and req together in IDLE: seed first, grant one cycle later,
      // four advances from 0110 give 1011.
      tick();
      seed_load = 1'b1;
      seed      = 4'b0110;
      req       = 4'b1000;
      push(4'b1000, 4'b1011);
      tick();
      seed_load = 1'b0;
      wait_valid(ncyc);
      check("t5_seed_wins_latency", 32'(ncyc), 32'd7);
      check("t5_lock_err_sticky", 32'(lock_err), 32'h1);
      req = 4'b0000;

      // Reset in STEP: no grant, everything back to reset values.
      tick();
      req = 4'b0001;
      tick();
      tick();
      reset = 1'b1;
      req   = 4'b0000;
      @(negedge clk);
      check("t6_gnt",      32'(gnt),      32'h0);
      check("t6_valid",    32'(valid),    32'h0);
      check("t6_busy",     32'(busy),     32'h0);
      check("t6_rnd",      32'(rnd),      32'h0);
      check("t6_lock_err", 32'(lock_err), 32'h0);
      tick();
      reset = 1'b0;
      nv = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (valid) nv++;
      end
      check("t6_no_grant_after_reset", 32'(nv), 32'h0);
      tick();
      req = 4'b0011;
      push(4'b0001, 4'b1010);
      wait_valid(ncyc);
      check("t6_latency", 32'(ncyc), 32'd7);
      req = 4'b0000;

      repeat (10) tick();
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
